// File: rtl/dmem_responder.sv
// dmem_responder
//   Responder end of the data-memory request channel. Takes one load or
//   store at a time, services it from an internal word array and returns
//   one response after LATENCY wait states.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   req_valid  request present
//   req_ready  responder can accept a request (registered)
//   req_we     1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data
//   req_be     store byte enables, bit i -> byte lane [8i+7:8i]
//   rsp_valid  response present (registered)
//   rsp_ready  requester accepts the response
//   rsp_rdata  load data; 0 for stores and for errors
//   rsp_err    request was misaligned or out of range
module dmem_responder #(
  parameter int WORD    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [WORD-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  input  logic [3:0]      req_be,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [WORD-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WORD-1:0] LIMIT = WORD'(DEPTH * 4);
  // Counter preload; only meaningful when LATENCY > 0.
  localparam logic [3:0] LAT_CNT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       req_ready_q, req_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_err_q, rsp_err_d;
  logic       rsp_load_q, rsp_load_d;

  logic [WORD-1:0] mem [DEPTH];
  logic [WORD-1:0] mem_rd_q;

  logic [AW-1:0] idx;
  logic          accept;
  logic          addr_err;
  logic          mem_wr;
  logic          mem_rd;

  assign idx      = req_addr[AW+1:2];
  assign accept   = req_valid && req_ready_q && (state_q == IDLE);
  assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr >= LIMIT);
  assign mem_wr   = accept && req_we && !addr_err;
  assign mem_rd   = accept && !req_we && !addr_err;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_load_d  = rsp_load_q;
    case (state_q)
      IDLE: begin
        // req_ready comes up on the first edge after reset release.
        req_ready_d = 1'b1;
        if (accept) begin
          req_ready_d = 1'b0;
          rsp_err_d   = addr_err;
          rsp_load_d  = !req_we && !addr_err;
          if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = LAT_CNT;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_load_q  <= rsp_load_d;
    end
  end

  // Array and its read register carry no reset so they map onto block RAM.
  // The read register is only loaded on an accepted load, so it holds the
  // response word steady for as long as the requester stalls.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be[b]) begin
          mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
    if (mem_rd) begin
      mem_rd_q <= mem[idx];
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  // Stores, errors and the post-reset state all present zero data.
  assign rsp_rdata = rsp_load_q ? mem_rd_q : '0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [3:0]  z_req_be;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          t;
  } exp_t;
  exp_t q[$];
  logic prev_v = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.WORD(32), .DEPTH(1024), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.WORD(32), .DEPTH(1024), .LATENCY(0)) dut0 (
    .clk(clk), .reset(rst_n),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event (cycle %0d)", nm, cyc);
  endtask

  // Present a request until accepted; optionally push its expected response.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input bit push,
                        input logic [31:0] exp_d, input logic exp_e);
    bit done = 0;
    exp_t x;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        done = 1;
        if (push) begin
          x.d = exp_d; x.e = exp_e; x.t = cyc + 1;  // accepting edge number
          q.push_back(x);
        end
      end
    end
    if (!done) fail_now("accept_timeout");
    @(posedge clk); #1;
    // Scramble the request bus after acceptance; it must have no effect.
    req_valid = 1'b0; req_addr = 32'h0000_0FFC; req_wdata = 32'h0BAD_0BAD; req_be = 4'hF; req_we = 1'b1;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !rsp_valid) done = 1;
    end
    if (!done) fail_now("response_timeout");
  endtask

  // Monitor: latency on the rising edge of rsp_valid, data/err at handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (rsp_valid && !prev_v) begin
        if (q.size() == 0) fail_now("unexpected_rsp");
        else chk("latency", 32'(cyc - q[0].t), 32'(LATENCY));
      end
      if (rsp_valid && rsp_ready && q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        $display("rsp cycle=%0d rdata=%h err=%0b exp_rdata=%h exp_err=%0b",
                 cyc, rsp_rdata, rsp_err, e.d, e.e);
        chk("rsp_rdata", rsp_rdata, e.d);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.e});
      end
      prev_v = rsp_valid;
    end
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 1;
    z_req_valid = 0; z_req_we = 0; z_req_addr = 0; z_req_wdata = 0; z_req_be = 0; z_rsp_ready = 1;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_z_req_ready", {31'd0, z_req_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic store then load.
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 32'h0, 1'b0);
    wait_idle();
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF, 1'b0);
    wait_idle();

    // Byte-lane merge, and a store with no lanes enabled.
    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 1, 32'h0, 1'b0);
    wait_idle();
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1, 32'h0, 1'b0);
    wait_idle();
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 1, 32'h11BB33DD, 1'b0);
    wait_idle();
    do_req(1'b1, 32'h20, 32'h99999999, 4'h0, 1, 32'h0, 1'b0);
    wait_idle();
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 1, 32'h11BB33DD, 1'b0);
    wait_idle();

    // Errors: misaligned load, out-of-range store must not touch word 0.
    do_req(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 1, 32'h0, 1'b0);
    wait_idle();
    do_req(1'b0, 32'h22, 32'h0, 4'h0, 1, 32'h0, 1'b1);
    wait_idle();
    do_req(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1, 32'h0, 1'b1);
    wait_idle();
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 1, 32'hCAFEF00D, 1'b0);
    wait_idle();
    do_req(1'b0, 32'h3FFC, 32'h0, 4'h0, 1, 32'h0, 1'b1);
    wait_idle();

    // Backpressure: response held for 5 cycles, requests ignored meanwhile.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF, 1'b0);
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (rsp_valid) seen = 1;
      end
      if (!seen) fail_now("bp_rsp_timeout");
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      req_valid = (i == 1 || i == 2);
      req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h12345678; req_be = 4'hF;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_req_ready_after", {31'd0, req_ready}, 32'd1);
    chk("bp_rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
    wait_idle();
    // The ignored store must not have landed.
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF, 1'b0);
    wait_idle();

    // LATENCY=0 instance: back-to-back loads, accept every second edge.
    @(posedge clk); #1;
    z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 32'h4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("z_req_ready", {31'd0, z_req_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("z_rsp_valid", {31'd0, z_rsp_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i % 2 == 1) $display("z rsp cycle=%0d err=%0b", cyc, z_rsp_err);
    end
    @(posedge clk); #1;
    z_req_valid = 1'b0;

    // Reset during WAIT: response dropped, accepted store already committed.
    do_req(1'b1, 32'h8, 32'h00000055, 4'hF, 0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
    chk("midrst_rsp_err", {31'd0, rsp_err}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_hold_valid", {31'd0, rsp_valid}, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_req(1'b0, 32'h8, 32'h0, 4'h0, 1, 32'h00000055, 1'b0);
    wait_idle();

    repeat (5) @(negedge clk);
    if (q.size() != 0) fail_now("queue_not_empty");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
